// File: rtl/move_scheduler.sv
// Tile-step move sequencer for the maze game: samples the buttons once per frame,
// checks the target tile against the wall store via req/ack and commits open moves.
module move_scheduler #(
  parameter int unsigned TILE         = 16,
  parameter int unsigned X_MIN        = 128,
  parameter int unsigned X_MAX        = 768,
  parameter int unsigned Y_MIN        = 35,
  parameter int unsigned Y_MAX        = 499,
  parameter int unsigned START_X      = 439,
  parameter int unsigned START_Y      = 266,
  parameter int unsigned REPEAT_DELAY = 15,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       moved,
  output logic       busy
);

  localparam int unsigned RptW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic signed [10:0] TileS = 11'(TILE);
  localparam logic signed [10:0] XMinS = 11'(X_MIN);
  localparam logic signed [10:0] XMaxS = 11'(X_MAX);
  localparam logic signed [10:0] YMinS = 11'(Y_MIN);
  localparam logic signed [10:0] YMaxS = 11'(Y_MAX);
  localparam logic [ToW-1:0]     ToLast = ToW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLookup, StCommit, StHold} state_e;
  typedef enum logic [1:0] {DirLeft, DirDown, DirUp, DirRight} dir_e;

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d, btn_dir, step_dir;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [9:0]      tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [RptW-1:0] rpt_q, rpt_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            any_btn, dir_held;
  logic signed [10:0] sx, sy, nx, ny;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= DirLeft;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      rpt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      rpt_q   <= rpt_d;
      to_q    <= to_d;
    end
  end

  // Priority left > down > up > right; buttons are active-low.
  always_comb begin
    any_btn = ~(btn_left & btn_down & btn_up & btn_right);
    if (!btn_left)      btn_dir = DirLeft;
    else if (!btn_down) btn_dir = DirDown;
    else if (!btn_up)   btn_dir = DirUp;
    else                btn_dir = DirRight;
    unique case (dir_q)
      DirLeft:  dir_held = ~btn_left;
      DirDown:  dir_held = ~btn_down;
      DirUp:    dir_held = ~btn_up;
      default:  dir_held = ~btn_right;
    endcase
  end

  // Target from the committed position, wrapping to the opposite edge.
  always_comb begin
    step_dir = (state_q == StIdle) ? btn_dir : dir_q;
    sx = $signed({1'b0, x_q});
    sy = $signed({1'b0, y_q});
    nx = sx;
    ny = sy;
    unique case (step_dir)
      DirLeft: begin
        nx = sx - TileS;
        if (nx < XMinS) nx = XMaxS;
      end
      DirRight: begin
        nx = sx + TileS;
        if (nx > XMaxS) nx = XMinS;
      end
      DirUp: begin
        ny = sy - TileS;
        if (ny < YMinS) ny = YMaxS;
      end
      default: begin
        ny = sy + TileS;
        if (ny > YMaxS) ny = YMinS;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    rpt_d   = rpt_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick && any_btn) begin
          state_d = StLookup;
          dir_d   = btn_dir;
          tgt_x_d = nx[9:0];
          tgt_y_d = ny[9:0];
          rpt_d   = RptW'(REPEAT_DELAY);
          to_d    = '0;
        end
      end
      StLookup: begin
        if (wall_ack) begin
          state_d = wall_hit ? StHold : StCommit;
        end else if (to_q == ToLast) begin
          state_d = StHold;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StCommit: begin
        x_d     = tgt_x_q;
        y_d     = tgt_y_q;
        state_d = StHold;
      end
      default: begin
        if (frame_tick) begin
          if (!dir_held) begin
            state_d = StIdle;
          end else if (rpt_q == RptW'(1)) begin
            state_d = StLookup;
            tgt_x_d = nx[9:0];
            tgt_y_d = ny[9:0];
            rpt_d   = RptW'(REPEAT_RATE);
            to_d    = '0;
          end else begin
            rpt_d = rpt_q - 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    wall_req = (state_q == StLookup);
    moved    = (state_q == StCommit);
    busy     = (state_q == StLookup) || (state_q == StCommit);
    wall_x   = tgt_x_q;
    wall_y   = tgt_y_q;
    x_pos    = x_q;
    y_pos    = y_q;
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: a background responder answers wall lookups
// with a configurable delay/hit, and each task checks one behaviour.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
  logic       wall_ack = 1'b0, wall_hit = 1'b0;
  logic       wall_req, moved, busy;
  logic [9:0] wall_x, wall_y, x_pos, y_pos;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   moved_cnt = 0;
  int   resp_delay = 3;
  logic resp_hit = 1'b0;
  bit   resp_en = 1'b1;
  int   req_cycles = 0;

  always #20 clk = ~clk;

  move_scheduler dut (
    .CLOCK_25   (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .wall_req   (wall_req),
    .wall_x     (wall_x),
    .wall_y     (wall_y),
    .wall_ack   (wall_ack),
    .wall_hit   (wall_hit),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .moved      (moved),
    .busy       (busy)
  );

  always @(negedge clk) if (moved === 1'b1) moved_cnt++;

  // Wall store model: ack during the resp_delay-th request cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (wall_req === 1'b1 && resp_en) begin
      req_cycles++;
      wall_ack = (req_cycles == resp_delay);
      wall_hit = (req_cycles == resp_delay) ? resp_hit : 1'b0;
    end else begin
      req_cycles = 0;
      wall_ack   = 1'b0;
      wall_hit   = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic release_all();
    btn_left = 1'b1; btn_down = 1'b1; btn_up = 1'b1; btn_right = 1'b1;
  endtask

  task automatic press(input int d);
    case (d)
      0: btn_left  = 1'b0;
      1: btn_down  = 1'b0;
      2: btn_up    = 1'b0;
      default: btn_right = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    release_all();
    step(2);
    reset = 1'b0;
  endtask

  // One isolated move: press, tick, release, then a release tick back to idle.
  task automatic single_step(input int d, output logic [9:0] rx, output logic [9:0] ry);
    press(d);
    tick();
    rx = wall_x;
    ry = wall_y;
    release_all();
    step(10);
    tick();
    step(2);
  endtask

  task automatic test_reset();
    int m0;
    do_reset();
    m0 = moved_cnt;
    n_checks += 5;
    if (x_pos !== 10'd439) begin n_fail++; $display("FAIL reset_x: got %0d expected 439", x_pos); end
    if (y_pos !== 10'd266) begin n_fail++; $display("FAIL reset_y: got %0d expected 266", y_pos); end
    if (wall_req !== 1'b0 || moved !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got req=%b moved=%b busy=%b expected 0 0 0", wall_req, moved, busy);
    end
    if (wall_x !== 10'd0) begin n_fail++; $display("FAIL reset_wall_x: got %0d expected 0", wall_x); end
    if (wall_y !== 10'd0) begin n_fail++; $display("FAIL reset_wall_y: got %0d expected 0", wall_y); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wall_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_tick%0d: got req=%b busy=%b expected 0 0", i, wall_req, busy);
      end
      step(5);
    end
    n_checks += 2;
    if (moved_cnt - m0 != 0) begin n_fail++; $display("FAIL idle_moved: got %0d expected 0", moved_cnt - m0); end
    if (x_pos !== 10'd439 || y_pos !== 10'd266) begin
      n_fail++; $display("FAIL idle_pos: got %0d,%0d expected 439,266", x_pos, y_pos);
    end
  endtask

  task automatic test_single_step();
    int m0;
    do_reset();
    m0 = moved_cnt;
    press(0);
    tick();
    release_all();
    n_checks += 3;
    if (wall_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL step_req: got req=%b busy=%b expected 1 1", wall_req, busy);
    end
    if (wall_x !== 10'd423) begin n_fail++; $display("FAIL step_wall_x: got %0d expected 423", wall_x); end
    if (wall_y !== 10'd266) begin n_fail++; $display("FAIL step_wall_y: got %0d expected 266", wall_y); end
    step(3);
    n_checks += 2;
    if (moved !== 1'b1) begin n_fail++; $display("FAIL step_commit_moved: got %b expected 1", moved); end
    if (x_pos !== 10'd439) begin n_fail++; $display("FAIL step_commit_x: got %0d expected 439", x_pos); end
    step(1);
    n_checks += 2;
    if (x_pos !== 10'd423) begin n_fail++; $display("FAIL step_x: got %0d expected 423", x_pos); end
    if (moved !== 1'b0 || busy !== 1'b0 || wall_req !== 1'b0) begin
      n_fail++; $display("FAIL step_after: got moved=%b busy=%b req=%b expected 0 0 0", moved, busy, wall_req);
    end
    step(10);
    tick();
    step(2);
    tick();
    n_checks += 2;
    if (wall_req !== 1'b0) begin n_fail++; $display("FAIL step_idle_req: got %b expected 0", wall_req); end
    if (moved_cnt - m0 != 1) begin n_fail++; $display("FAIL step_moved_cnt: got %0d expected 1", moved_cnt - m0); end
  endtask

  task automatic test_auto_repeat();
    int m0;
    do_reset();
    m0 = moved_cnt;
    press(0);
    for (int t = 0; t <= 30; t++) begin
      if (t == 10) btn_down = 1'b0;
      tick();
      step(19);
      if (t == 14) begin
        n_checks++;
        if (x_pos !== 10'd423) begin n_fail++; $display("FAIL rpt_t14_x: got %0d expected 423", x_pos); end
      end
      if (t == 15) begin
        n_checks++;
        if (x_pos !== 10'd407) begin n_fail++; $display("FAIL rpt_t15_x: got %0d expected 407", x_pos); end
      end
    end
    release_all();
    tick();
    step(3);
    n_checks += 4;
    if (x_pos !== 10'd359) begin n_fail++; $display("FAIL rpt_final_x: got %0d expected 359", x_pos); end
    if (y_pos !== 10'd266) begin n_fail++; $display("FAIL rpt_no_redirect_y: got %0d expected 266", y_pos); end
    if (moved_cnt - m0 != 5) begin n_fail++; $display("FAIL rpt_moved_cnt: got %0d expected 5", moved_cnt - m0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rpt_busy: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [9:0] rx, ry;
    do_reset();
    for (int i = 0; i < 21; i++) single_step(3, rx, ry);
    n_checks++;
    if (x_pos !== 10'd128) begin n_fail++; $display("FAIL wrap_right_x: got %0d expected 128", x_pos); end
    single_step(0, rx, ry);
    n_checks += 2;
    if (rx !== 10'd768) begin n_fail++; $display("FAIL wrap_left_wall_x: got %0d expected 768", rx); end
    if (x_pos !== 10'd768) begin n_fail++; $display("FAIL wrap_left_x: got %0d expected 768", x_pos); end
    for (int i = 0; i < 15; i++) single_step(2, rx, ry);
    n_checks++;
    if (y_pos !== 10'd499) begin n_fail++; $display("FAIL wrap_up_y: got %0d expected 499", y_pos); end
    single_step(1, rx, ry);
    n_checks += 2;
    if (ry !== 10'd35) begin n_fail++; $display("FAIL wrap_down_wall_y: got %0d expected 35", ry); end
    if (y_pos !== 10'd35) begin n_fail++; $display("FAIL wrap_down_y: got %0d expected 35", y_pos); end
  endtask

  task automatic test_wall_hit();
    int m0;
    do_reset();
    resp_hit = 1'b1;
    m0 = moved_cnt;
    press(0);
    tick();
    n_checks++;
    if (wall_req !== 1'b1) begin n_fail++; $display("FAIL hit_req: got %b expected 1", wall_req); end
    step(10);
    tick();
    step(5);
    release_all();
    tick();
    step(2);
    tick();
    n_checks += 3;
    if (x_pos !== 10'd439 || y_pos !== 10'd266) begin
      n_fail++; $display("FAIL hit_pos: got %0d,%0d expected 439,266", x_pos, y_pos);
    end
    if (moved_cnt - m0 != 0) begin n_fail++; $display("FAIL hit_moved: got %0d expected 0", moved_cnt - m0); end
    if (wall_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hit_idle: got req=%b busy=%b expected 0 0", wall_req, busy);
    end
    resp_hit = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    logic [9:0] rx, ry;
    do_reset();
    resp_en = 1'b0;
    press(0);
    tick();
    n = 0;
    while (wall_req === 1'b1 && n < 400) begin
      n++;
      step(1);
    end
    n_checks += 2;
    if (n != 255) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 255", n); end
    if (x_pos !== 10'd439 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pos: got x=%0d busy=%b expected 439 0", x_pos, busy);
    end
    release_all();
    tick();
    step(2);
    resp_en = 1'b1;
    single_step(0, rx, ry);
    n_checks++;
    if (x_pos !== 10'd423) begin n_fail++; $display("FAIL pre_reset_x: got %0d expected 423", x_pos); end
    resp_en = 1'b0;
    press(0);
    tick();
    step(5);
    n_checks++;
    if (wall_req !== 1'b1) begin n_fail++; $display("FAIL midlookup_req: got %b expected 1", wall_req); end
    reset = 1'b1;
    step(1);
    n_checks += 3;
    if (wall_req !== 1'b0 || busy !== 1'b0 || moved !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got req=%b busy=%b moved=%b expected 0 0 0", wall_req, busy, moved);
    end
    if (x_pos !== 10'd439 || y_pos !== 10'd266) begin
      n_fail++; $display("FAIL midreset_pos: got %0d,%0d expected 439,266", x_pos, y_pos);
    end
    if (wall_x !== 10'd0) begin n_fail++; $display("FAIL midreset_wall_x: got %0d expected 0", wall_x); end
    reset = 1'b0;
    release_all();
    resp_en = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_auto_repeat();
    test_wrap();
    test_wall_hit();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
